// File: rtl/sha3_padder.sv
// SHA-3 rate-block padder: packs a byte stream into R_BLOCK_SIZE-bit blocks and
// applies pad10*1 with a domain-separation byte on the final block of each message.
module sha3_padder #(
  parameter int unsigned R_BLOCK_SIZE = 1152,
  parameter logic [7:0]  DS           = 8'h06
) (
  input  logic                    CLK,
  input  logic                    A_RST_N,
  input  logic [7:0]              IN_DATA,
  input  logic                    IN_VALID,
  input  logic                    IN_LAST,
  input  logic                    IN_KEEP,
  output logic                    IN_READY,
  output logic [0:R_BLOCK_SIZE-1] OUT_BLOCK,
  output logic                    OUT_VALID,
  output logic                    OUT_LAST,
  input  logic                    OUT_READY
);

  localparam int unsigned RBytes  = R_BLOCK_SIZE / 8;
  localparam int unsigned CntW    = (RBytes > 1) ? $clog2(RBytes) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RBytes - 1);
  localparam int unsigned LastBit = 8 * (RBytes - 1);

  typedef enum logic [1:0] {StFill, StPad, StEmit} state_e;

  state_e                  state;
  logic [CntW-1:0]         cnt;
  logic                    pad_pending;
  logic                    last;
  logic [0:R_BLOCK_SIZE-1] blk;

  // Handshakes are pure functions of state, forced low while reset is held.
  assign IN_READY  = A_RST_N && (state == StFill);
  assign OUT_VALID = A_RST_N && (state == StEmit);
  assign OUT_BLOCK = blk;
  assign OUT_LAST  = last;

  // Single FSM: byte packing, padding and block hand-off.
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state       <= StFill;
      cnt         <= '0;
      pad_pending <= 1'b0;
      last        <= 1'b0;
      blk         <= '0;
    end else begin
      unique case (state)
        StFill: begin
          if (IN_VALID) begin
            if (IN_LAST && !IN_KEEP) begin
              // Empty final beat: nothing stored, pad at current position.
              state <= StPad;
            end else begin
              blk[{cnt, 3'b000} +: 8] <= IN_DATA;
              if (cnt == CntMax) begin
                // Block full; a final byte here means padding spills into a new block.
                state       <= StEmit;
                last        <= 1'b0;
                pad_pending <= IN_LAST;
              end else begin
                cnt <= cnt + 1'b1;
                if (IN_LAST) state <= StPad;
              end
            end
          end
        end
        StPad: begin
          if (cnt == CntMax) begin
            // Domain byte and the trailing 1-bit share the last byte.
            blk[LastBit +: 8] <= DS | 8'h80;
          end else begin
            blk[{cnt, 3'b000} +: 8] <= DS;
            blk[LastBit +: 8]       <= blk[LastBit +: 8] | 8'h80;
          end
          last  <= 1'b1;
          state <= StEmit;
        end
        StEmit: begin
          if (OUT_READY) begin
            blk  <= '0;
            cnt  <= '0;
            last <= 1'b0;
            if (pad_pending) begin
              pad_pending <= 1'b0;
              state       <= StPad;
            end else begin
              state <= StFill;
            end
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: two instances (default DS and DS=8'h01) share stimulus.
module tb_sha3_padder;

  localparam int unsigned RBits  = 1152;
  localparam int unsigned RBytes = RBits / 8;

  logic             clk;
  logic             a_rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_keep;
  logic             in_ready;
  logic             in_ready_b;
  logic [0:RBits-1] out_block;
  logic [0:RBits-1] out_block_b;
  logic             out_valid;
  logic             out_valid_b;
  logic             out_last;
  logic             out_last_b;
  logic             out_ready;

  int n_vec;
  int n_err;
  logic [7:0] exp_blk [RBytes];

  sha3_padder #(.R_BLOCK_SIZE(RBits)) dut (
    .CLK(clk), .A_RST_N(a_rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_LAST(in_last), .IN_KEEP(in_keep), .IN_READY(in_ready),
    .OUT_BLOCK(out_block), .OUT_VALID(out_valid), .OUT_LAST(out_last),
    .OUT_READY(out_ready)
  );

  sha3_padder #(.R_BLOCK_SIZE(RBits), .DS(8'h01)) dut_b (
    .CLK(clk), .A_RST_N(a_rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_LAST(in_last), .IN_KEEP(in_keep), .IN_READY(in_ready_b),
    .OUT_BLOCK(out_block_b), .OUT_VALID(out_valid_b), .OUT_LAST(out_last_b),
    .OUT_READY(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_clear();
    for (int i = 0; i < RBytes; i++) exp_blk[i] = 8'h00;
  endtask

  task automatic check_blk(input string tag, input logic use_b);
    logic [7:0] got;
    for (int k = 0; k < RBytes; k++) begin
      got = use_b ? out_block_b[8*k +: 8] : out_block[8*k +: 8];
      chk($sformatf("%s[%0d]", tag, k), {24'h0, got}, {24'h0, exp_blk[k]});
    end
  endtask

  // Caller sits 1 time unit after a rising edge; returns likewise after acceptance.
  task automatic send(input logic [7:0] d, input logic lst, input logic keep);
    int n;
    n = 0;
    in_data = d; in_valid = 1'b1; in_last = lst; in_keep = keep;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b1;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // 53 58 7B 99 on the DS=8'h01 instance, including PAD latency.
  task automatic msg4(input string tag);
    send(8'h53, 1'b0, 1'b1);
    send(8'h58, 1'b0, 1'b1);
    send(8'h7B, 1'b0, 1'b1);
    send(8'h99, 1'b1, 1'b1);
    chk({tag, "_pad_cycle_valid"}, {31'd0, out_valid_b}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_emit_valid"}, {31'd0, out_valid_b}, 32'd1);
    chk({tag, "_emit_last"}, {31'd0, out_last_b}, 32'd1);
    exp_clear();
    exp_blk[0] = 8'h53; exp_blk[1] = 8'h58; exp_blk[2] = 8'h7B; exp_blk[3] = 8'h99;
    exp_blk[4] = 8'h01; exp_blk[RBytes-1] = 8'h80;
    check_blk(tag, 1'b1);
    chk({tag, "_default_ds_byte4"}, {24'h0, out_block[32 +: 8]}, 32'h06);
    consume();
    chk({tag, "_back_to_fill"}, {31'd0, in_ready_b}, 32'd1);
  endtask

  task automatic pulse_reset();
    #2 a_rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    @(negedge clk) a_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    a_rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b1;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid_low", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last_low", {31'd0, out_last}, 32'd0);
    chk("rst_block_zero", {31'd0, |out_block}, 32'd0);
    @(negedge clk) a_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Short message with DS=8'h01
    msg4("m4");

    // Empty message
    send(8'h00, 1'b1, 1'b0);
    wait_out();
    chk("empty_last", {31'd0, out_last}, 32'd1);
    exp_clear();
    exp_blk[0] = 8'h06; exp_blk[RBytes-1] = 8'h80;
    check_blk("empty", 1'b0);
    consume();

    // 143-byte message: pad bytes merge into 8'h86
    for (int i = 0; i < RBytes - 1; i++) send(i[7:0], (i == RBytes - 2), 1'b1);
    wait_out();
    chk("m143_last", {31'd0, out_last}, 32'd1);
    exp_clear();
    for (int i = 0; i < RBytes - 1; i++) exp_blk[i] = i[7:0];
    exp_blk[RBytes-1] = 8'h86;
    check_blk("m143", 1'b0);
    consume();

    // 144-byte message: full block out immediately, padding in a second block
    for (int i = 0; i < RBytes; i++) send(i[7:0], (i == RBytes - 1), 1'b1);
    chk("m144_b1_valid_now", {31'd0, out_valid}, 32'd1);
    chk("m144_b1_last", {31'd0, out_last}, 32'd0);
    exp_clear();
    for (int i = 0; i < RBytes; i++) exp_blk[i] = i[7:0];
    check_blk("m144_b1", 1'b0);

    // Back-pressure with a pending input beat
    in_data = 8'hAA; in_valid = 1'b1; in_last = 1'b1; in_keep = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_b0", {24'h0, out_block[0 +: 8]}, 32'h00);
      chk("stall_b143", {24'h0, out_block[8*(RBytes-1) +: 8]}, 32'h8F);
      chk("stall_last", {31'd0, out_last}, 32'd0);
    end
    consume();
    chk("m144_pad_in_ready", {31'd0, in_ready}, 32'd0);
    wait_out();
    chk("m144_b2_last", {31'd0, out_last}, 32'd1);
    exp_clear();
    exp_blk[0] = 8'h06; exp_blk[RBytes-1] = 8'h80;
    check_blk("m144_b2", 1'b0);
    consume();

    // Held beat lands at byte 0 of the next message
    send(8'hAA, 1'b1, 1'b1);
    wait_out();
    exp_clear();
    exp_blk[0] = 8'hAA; exp_blk[1] = 8'h06; exp_blk[RBytes-1] = 8'h80;
    check_blk("held", 1'b0);
    chk("held_last", {31'd0, out_last}, 32'd1);
    consume();

    // Reset after 50 bytes discards the partial block
    for (int i = 0; i < 50; i++) send(8'hC0 ^ i[7:0], 1'b0, 1'b1);
    pulse_reset();
    msg4("after_rst50");

    // Reset mid-EMIT
    for (int i = 0; i < RBytes; i++) send(8'h5A, 1'b0, 1'b1);
    chk("pre_rst_emit_valid", {31'd0, out_valid}, 32'd1);
    pulse_reset();
    msg4("after_rst_emit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter R_BLOCK_SIZE, default 1152, meaning rate block width in bits (multiple of 8; R_BYTES = R_BLOCK_SIZE/8).
REQ-002 SHALL have parameter DS, default 8'h06, meaning domain-separation/first pad byte.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port A_RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IN_DATA  input  8  message byte.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA valid.
REQ-007 SHALL have port IN_LAST  input  1  final beat of message.
REQ-008 SHALL have port IN_KEEP  input  1  IN_DATA is a message byte; IN_KEEP=0 is legal only with IN_LAST=1 (empty final beat).
REQ-009 SHALL have port IN_READY  output  1  byte accepted when IN_VALID&&IN_READY.
REQ-010 SHALL have port OUT_BLOCK  output  [0:R_BLOCK_SIZE-1]  rate block for the permutation stage; byte k at OUT_BLOCK[8k:8k+7], OUT_BLOCK[8k] = byte MSB.
REQ-011 SHALL have port OUT_VALID  output  1  OUT_BLOCK valid.
REQ-012 SHALL have port OUT_LAST  output  1  OUT_BLOCK is the final (padded) block of the message.
REQ-013 SHALL have port OUT_READY  input  1  block consumed when OUT_VALID&&OUT_READY.

Function
REQ-014 SHALL implement states FILL, PAD, EMIT plus flag pad_pending, byte counter cnt (0..R_BYTES-1), registered R_BLOCK_SIZE-bit buffer driving OUT_BLOCK.
REQ-015 SHALL drive IN_READY=1 only in FILL and OUT_VALID=1 only in EMIT; both combinational from state.
REQ-016 FILL, accepted beat, not IN_LAST, cnt<R_BYTES-1: store IN_DATA at byte cnt, cnt++.
REQ-017 FILL, accepted beat, not IN_LAST, cnt==R_BYTES-1: store byte, go EMIT, OUT_LAST=0.
REQ-018 FILL, accepted IN_LAST with IN_KEEP=1, cnt<R_BYTES-1: store byte, cnt++, go PAD.
REQ-019 FILL, accepted IN_LAST with IN_KEEP=1, cnt==R_BYTES-1: store byte, set pad_pending, go EMIT, OUT_LAST=0.
REQ-020 FILL, accepted IN_LAST with IN_KEEP=0: store nothing, cnt unchanged, go PAD.
REQ-021 PAD (one cycle): byte cnt := DS; byte R_BYTES-1 := byte R_BYTES-1 | 8'h80 (same byte when cnt==R_BYTES-1, giving 8'h86 for DS=8'h06); set OUT_LAST=1; go EMIT.
REQ-022 EMIT: OUT_BLOCK, OUT_LAST SHALL hold stable while OUT_READY=0.
REQ-023 EMIT with OUT_READY=1: clear buffer to zero, cnt:=0, OUT_LAST:=0; if pad_pending then clear it and go PAD, else go FILL.
REQ-024 Latency: block-completing byte accepted at edge t -> OUT_VALID high after edge t; final-byte accept at t -> PAD after t, OUT_VALID after t+1.
REQ-025 SHALL never drop or duplicate a byte under any IN_VALID/OUT_READY pattern; beats offered outside FILL SHALL be held off via IN_READY=0.
REQ-026 Multiple messages SHALL be processed back-to-back without reset; each message starts at cnt=0 of a cleared buffer.

Reset
REQ-027 A_RST_N=0 SHALL asynchronously force state FILL, cnt=0, pad_pending=0, buffer=0, OUT_LAST=0; IN_READY and OUT_VALID SHALL be 0 while A_RST_N=0.
REQ-028 Reset mid-message or mid-EMIT SHALL discard all partial data; first beat after deassertion is byte 0 of a new message.

Verification
REQ-029 4 bytes 53,58,7B,99 (last on 99), DS=8'h01 -> one block bytes0-4=53 58 7B 99 01, bytes5-142=00, byte143=80, OUT_LAST=1.
REQ-030 Empty message (IN_LAST=1, IN_KEEP=0), default DS -> byte0=06, bytes1-142=00, byte143=80, OUT_LAST=1.
REQ-031 143-byte message 00..8E -> one block bytes0-142 = message, byte143=86, OUT_LAST=1.
REQ-032 144-byte message -> block1 = 144 message bytes, OUT_LAST=0; then block2 byte0=06, byte143=80, rest 00, OUT_LAST=1.
REQ-033 OUT_READY=0 for 10 cycles during EMIT with IN_VALID=1 -> OUT_BLOCK constant, IN_READY=0, next message byte lands at byte0 of next block.
REQ-034 A_RST_N pulsed low after 50 bytes -> OUT_VALID=0 immediately; subsequent 4-byte message yields exactly the REQ-029 pattern (no stale bytes).
